// File: rtl/mu0_sequencer_if.sv
// -----------------------------------------------------------------------------
// mu0_sequencer_if
//
// Purpose: bundles every signal that passes between the MU0 control sequencer
// and the datapath/memory side. The sequencer uses the master modport; the
// datapath/memory model (or a testbench) uses the slave modport.
//
// Signals
//   opcode     datapath -> sequencer   IR[15:12]
//   acc_zero   datapath -> sequencer   accumulator == 0
//   acc_neg    datapath -> sequencer   accumulator bit 15
//   mem_ready  memory   -> sequencer   current request completes this cycle
//   mem_req    sequencer -> memory     memory request active
//   mem_we     sequencer -> memory     write request (STO)
//   addr_sel   sequencer -> datapath   0 = PC drives address, 1 = IR[11:0]
//   ir_load    sequencer -> datapath   IR <= memory data
//   pc_inc     sequencer -> datapath   PC <= PC + 1
//   pc_load    sequencer -> datapath   PC <= IR[11:0]
//   acc_load   sequencer -> datapath   ACC <= ALU result
//   alu_op     sequencer -> datapath   00 pass, 01 add, 10 subtract
//   phase      sequencer -> observer   00 FETCH, 01 DECODE, 10 EXEC_MEM, 11 HALT/ERROR
//   halted     sequencer -> observer   sticky, set by STP
//   bus_error  sequencer -> observer   sticky, set by memory timeout
// -----------------------------------------------------------------------------
interface mu0_sequencer_if;
  logic [3:0] opcode;
  logic       acc_zero;
  logic       acc_neg;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic       ir_load;
  logic       pc_inc;
  logic       pc_load;
  logic       acc_load;
  logic [1:0] alu_op;
  logic [1:0] phase;
  logic       halted;
  logic       bus_error;

  // Sequencer side: observes datapath flags and memory, drives strobes.
  modport master (
    input  opcode, acc_zero, acc_neg, mem_ready,
    output mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, acc_load,
    output alu_op, phase, halted, bus_error
  );

  // Datapath/memory side: mirror image of the master.
  modport slave (
    output opcode, acc_zero, acc_neg, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, acc_load,
    input  alu_op, phase, halted, bus_error
  );
endinterface

// File: rtl/mu0_sequencer.sv
// -----------------------------------------------------------------------------
// mu0_sequencer
//
// Purpose: control sequencer for the MU0 datapath. Every instruction is
// stepped through FETCH, DECODE and (for memory instructions) EXEC_MEM.
// The sequencer owns a single shared memory port with a ready handshake,
// stops permanently on STP, and enters an error state if a memory request
// is not answered within MAX_WAIT extra cycles.
//
// Parameters
//   MAX_WAIT  maximum extra wait cycles per memory request; 0 disables the
//             timeout entirely.
//
// Ports
//   clk   system clock, all state on the rising edge
//   rst   synchronous, active-high reset; forces every output low while high
//   bus   mu0_sequencer_if.master (datapath flags, memory handshake, strobes)
//
// Opcodes: 0 LDA, 1 STO, 2 ADD, 3 SUB, 4 JMP, 5 JGE, 6 JNE, 7 STP, 8-15 NOP.
// -----------------------------------------------------------------------------
module mu0_sequencer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  mu0_sequencer_if.master bus
);

  // A zero MAX_WAIT would give a zero-width counter, so keep at least one bit.
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
  localparam bit TIMEOUT_EN = (MAX_WAIT != 0);

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STO = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  localparam logic [1:0] PH_FETCH  = 2'b00;
  localparam logic [1:0] PH_DECODE = 2'b01;
  localparam logic [1:0] PH_EXEC   = 2'b10;
  localparam logic [1:0] PH_STOP   = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_MEM,
    S_HALT,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             halted_q, halted_d;
  logic             bus_error_q, bus_error_d;

  logic             in_mem;
  logic             timeout;

  logic             mem_req_c;
  logic             mem_we_c;
  logic             addr_sel_c;
  logic             ir_load_c;
  logic             pc_inc_c;
  logic             pc_load_c;
  logic             acc_load_c;
  logic [1:0]       alu_op_c;
  logic [1:0]       phase_c;
  logic             halted_c;
  logic             bus_error_c;

  // A request is outstanding in both memory states. The timeout fires on the
  // last tolerated wait cycle (counter already at the limit, still no ready),
  // so the error state is entered on the following cycle, k = MAX_WAIT + 1.
  always_comb begin
    in_mem  = (state_q == S_FETCH) || (state_q == S_EXEC_MEM);
    timeout = TIMEOUT_EN && in_mem && !bus.mem_ready && (wait_q == WAIT_LIMIT);
  end

  // Next-state and strobe decode. Outputs are combinational from the current
  // state, opcode, flags and mem_ready so that each strobe lands in the very
  // cycle the datapath must act on it. The wait counter defaults to zero,
  // which clears it on any accepted response and on every cycle outside a
  // memory state, so it always starts a new request at zero.
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    halted_d    = halted_q;
    bus_error_d = bus_error_q;

    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    addr_sel_c  = 1'b0;
    ir_load_c   = 1'b0;
    pc_inc_c    = 1'b0;
    pc_load_c   = 1'b0;
    acc_load_c  = 1'b0;
    alu_op_c    = ALU_PASS;
    phase_c     = PH_FETCH;
    halted_c    = halted_q;
    bus_error_c = bus_error_q;

    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b0;
        phase_c    = PH_FETCH;
        if (bus.mem_ready) begin
          ir_load_c = 1'b1;
          pc_inc_c  = 1'b1;
          state_d   = S_DECODE;
        end else if (timeout) begin
          state_d     = S_ERROR;
          bus_error_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_DECODE: begin
        phase_c = PH_DECODE;
        case (bus.opcode)
          OP_LDA, OP_STO, OP_ADD, OP_SUB: begin
            state_d = S_EXEC_MEM;
          end
          OP_JMP: begin
            pc_load_c = 1'b1;
            state_d   = S_FETCH;
          end
          OP_JGE: begin
            pc_load_c = ~bus.acc_neg;
            state_d   = S_FETCH;
          end
          OP_JNE: begin
            pc_load_c = ~bus.acc_zero;
            state_d   = S_FETCH;
          end
          OP_STP: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          default: begin
            state_d = S_FETCH;
          end
        endcase
      end

      // The write enable is held for the whole request, including the wait
      // cycles, because the memory may sample it on any of them.
      S_EXEC_MEM: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = (bus.opcode == OP_STO);
        phase_c    = PH_EXEC;
        if (bus.mem_ready) begin
          case (bus.opcode)
            OP_LDA: begin
              acc_load_c = 1'b1;
              alu_op_c   = ALU_PASS;
            end
            OP_ADD: begin
              acc_load_c = 1'b1;
              alu_op_c   = ALU_ADD;
            end
            OP_SUB: begin
              acc_load_c = 1'b1;
              alu_op_c   = ALU_SUB;
            end
            default: begin
              acc_load_c = 1'b0;
            end
          endcase
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d     = S_ERROR;
          bus_error_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_HALT: begin
        phase_c = PH_STOP;
      end

      S_ERROR: begin
        phase_c = PH_STOP;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset has to silence the port immediately, even mid-request, so no
    // strobe can reach the datapath in the reset cycle.
    if (rst) begin
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      addr_sel_c  = 1'b0;
      ir_load_c   = 1'b0;
      pc_inc_c    = 1'b0;
      pc_load_c   = 1'b0;
      acc_load_c  = 1'b0;
      alu_op_c    = ALU_PASS;
      phase_c     = PH_FETCH;
      halted_c    = 1'b0;
      bus_error_c = 1'b0;
    end
  end

  // State, wait counter and the two sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      halted_q    <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      halted_q    <= halted_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.addr_sel  = addr_sel_c;
  assign bus.ir_load   = ir_load_c;
  assign bus.pc_inc    = pc_inc_c;
  assign bus.pc_load   = pc_load_c;
  assign bus.acc_load  = acc_load_c;
  assign bus.alu_op    = alu_op_c;
  assign bus.phase     = phase_c;
  assign bus.halted    = halted_c;
  assign bus.bus_error = bus_error_c;

endmodule
